// File: rtl/fetch_pkg.sv
//==============================================================================
// Module   : fetch_pkg
// Brief    : Shared constants and entry type for the instruction-fetch stage.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package fetch_pkg;

    localparam int unsigned      c_addr_width   = 32;
    localparam int unsigned      c_instr_width  = 32;
    localparam int unsigned      c_pc_incr      = 4;
    localparam logic [31:0]      c_reset_vector = 32'h0000_0000;

    typedef struct packed {
        logic [c_addr_width-1:0]  pc;
        logic [c_instr_width-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//==============================================================================
// Module   : fetch_fifo
// Brief    : 2-entry synchronous FIFO with flush; head holds its last value
//            while empty so downstream outputs stay stable.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [c_cnt_w-1:0]    count_q;
    logic                  w_drain;

    // Draining the last entry leaves the read pointer in place so the head keeps showing it.
    assign w_drain = pop_i && !push_i && (count_q == c_cnt_w'(1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (flush_i || w_drain) begin
            wr_ptr_q <= rd_ptr_q;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + c_cnt_w'(1);
                2'b01:   count_q <= count_q - c_cnt_w'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//==============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage: PC register, memory address, 2-entry
//            instruction buffer toward decode, redirect handling.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = c_addr_width,
    parameter int unsigned           INSTR_WIDTH  = c_instr_width,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(c_reset_vector),
    parameter int unsigned           FIFO_DEPTH   = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic [INSTR_WIDTH-1:0] imem_rd_i,
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_plus4_o,
    output logic                   misalign_o
);

    localparam int unsigned c_entry_w = ADDR_WIDTH + INSTR_WIDTH;
    localparam int unsigned c_cnt_w   = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  misalign_q;
    logic                  misalign_d;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    logic                  w_full;
    logic [c_cnt_w-1:0]    w_count;
    logic [c_entry_w-1:0]  w_head;

    assign w_valid = (w_count != '0);
    assign w_full  = (w_count == c_cnt_w'(FIFO_DEPTH));

    // Redirect voids any concurrent handshake and blocks the in-flight word.
    always_comb begin
        w_pop      = w_valid && instr_ready_i && !redirect_i;
        w_push     = !redirect_i && (!w_full || w_pop);
        misalign_d = redirect_i && (redirect_pc_i[1:0] != 2'b00);
        pc_d       = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (w_push) begin
            pc_d = pc_q + ADDR_WIDTH'(c_pc_incr);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_fifo #(
        .DATA_WIDTH (c_entry_w),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (reset_n_i),
        .flush_i (redirect_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  ({pc_q, imem_rd_i}),
        .data_o  (w_head),
        .count_o (w_count)
    );

    assign imem_addr_o      = pc_q;
    assign instr_valid_o    = w_valid;
    assign instr_pc_o       = w_head[c_entry_w-1:INSTR_WIDTH];
    assign instr_o          = w_head[INSTR_WIDTH-1:0];
    assign instr_pc_plus4_o = instr_pc_o + ADDR_WIDTH'(c_pc_incr);
    assign misalign_o       = misalign_q;

endmodule

`default_nettype wire
